// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues sequential reads to a 1-cycle sync imem and registers word+PC into the IF/ID stage.
// Latency: request in cycle k, data in k+1, id_valid in k+2; redirect target appears 3 cycles after redirect.
// Backpressure: stall holds id_*; a response arriving under stall parks in a 1-entry skid, issue pauses until it drains.
// Optional build macro IFU_PERF_CNT_EN adds fetch_cnt / bubble_cnt accepted/bubble counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  // One fetched instruction with the address it came from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  logic [31:0]  pc_q;          // next address to request
  logic [31:0]  req_pc_q;      // address of the request whose data arrives this cycle
  logic         inflight_q;    // a response is on imem_rdata this cycle
  logic         skid_vld_q;
  fetch_entry_t skid_q;

  fetch_entry_t rsp;
  fetch_entry_t id_src;
  logic         load_id;
  logic         issue;
  logic [31:0]  redirect_tgt;

  // Targets are word aligned; the low two bits of the request are dropped.
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  // Live response pairs the memory word with the PC captured at issue time.
  assign rsp = {imem_rdata, req_pc_q};

  // No issue when the skid is occupied or when a stalled response is about to
  // take the skid; together these guarantee at most one parked instruction.
  assign issue     = !rst && !redirect && !skid_vld_q && !(stall && inflight_q);
  assign imem_en   = issue;
  assign imem_addr = pc_q;

  // Pick what the IF/ID register takes when decode accepts: parked entry first, then live data.
  always_comb begin
    id_src  = rsp;
    load_id = 1'b0;
    if (skid_vld_q) begin
      id_src  = skid_q;
      load_id = 1'b1;
    end else if (inflight_q) begin
      id_src  = rsp;
      load_id = 1'b1;
    end
  end

  // PC sequencing and in-flight tracking; a redirect drops any outstanding response.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else if (redirect) begin
      pc_q       <= redirect_tgt;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q     <= pc_q + PC_STEP;
        req_pc_q <= pc_q;
      end
    end
  end

  // Skid entry: filled by a response arriving under stall, emptied when decode accepts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
    end else if (redirect) begin
      skid_vld_q <= 1'b0;
    end else if (stall) begin
      if (inflight_q && !skid_vld_q) begin
        skid_vld_q <= 1'b1;
        skid_q     <= rsp;
      end
    end else begin
      skid_vld_q <= 1'b0;
    end
  end

  // IF/ID register: holds under stall, bubbles (data held) when nothing is available.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
      id_pc4   <= '0;
    end else if (redirect) begin
      id_valid <= 1'b0;
    end else if (!stall) begin
      id_valid <= load_id;
      if (load_id) begin
        id_instr <= id_src.instr;
        id_pc    <= id_src.pc;
        id_pc4   <= id_src.pc + 32'd4;
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Accepted-instruction and bubble counters, sampled where decode is ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (!stall) begin
      if (id_valid) begin
        fetch_cnt  <= fetch_cnt + 32'd1;
      end else begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle synchronous memory model.
// Each task drives a scenario cycle by cycle and compares against hand-derived values.
// Inputs change 1 time unit after posedge; outputs are compared 2 units after posedge.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_rdata = '0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: mem[a] = a ^ 32'hA5A5_0000, one cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem_addr ^ 32'hA5A5_0000;
  end

  instr_fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .imem_en(imem_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .id_valid(id_valid),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .id_pc4(id_pc4)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_cnt(fetch_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  // Advance one cycle and apply this cycle's inputs.
  task automatic cyc(input logic r, input logic s, input logic d, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    rst = r;
    stall = s;
    redirect = d;
    redirect_pc = tgt;
    #1;
  endtask

  task automatic test_reset;
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", id_instr); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", id_pc); end
    checks++; if (id_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h want 0", id_pc4); end
    checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", imem_en); end
    // cycle 0: first request
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_en !== 1'b1) begin errors++; $display("FAIL c0_en: got %b want 1", imem_en); end
    checks++; if (imem_addr !== 32'h3000) begin errors++; $display("FAIL c0_addr: got %h want 3000", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL c0_valid: got %b want 0", id_valid); end
    // cycle 1: data in flight, nothing presented yet
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL c1_valid: got %b want 0", id_valid); end
    checks++; if (imem_addr !== 32'h3004) begin errors++; $display("FAIL c1_addr: got %h want 3004", imem_addr); end
  endtask

  task automatic test_stream;
    logic [31:0] exp;
    for (int c = 2; c <= 9; c++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      exp = 32'h3000 + 32'(4 * (c - 2));
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b want 1", c, id_valid); end
      checks++; if (id_pc !== exp) begin errors++; $display("FAIL stream_pc[%0d]: got %h want %h", c, id_pc, exp); end
      checks++; if (id_instr !== (exp ^ 32'hA5A5_0000)) begin errors++; $display("FAIL stream_instr[%0d]: got %h want %h", c, id_instr, exp ^ 32'hA5A5_0000); end
      checks++; if (id_pc4 !== exp + 32'd4) begin errors++; $display("FAIL stream_pc4[%0d]: got %h want %h", c, id_pc4, exp + 32'd4); end
      checks++; if (imem_addr !== 32'h3000 + 32'(4 * c)) begin errors++; $display("FAIL stream_addr[%0d]: got %h want %h", c, imem_addr, 32'h3000 + 32'(4 * c)); end
    end
`ifdef IFU_PERF_CNT_EN
    checks++; if (fetch_cnt !== 32'd7) begin errors++; $display("FAIL perf_fetch: got %0d want 7", fetch_cnt); end
    checks++; if (bubble_cnt !== 32'd2) begin errors++; $display("FAIL perf_bubble: got %0d want 2", bubble_cnt); end
`endif
  endtask

  task automatic test_stall;
    logic        st  [8];
    logic        ev  [8];
    logic [31:0] epc [8];
    logic        een [8];
    logic [31:0] ead [8];
    st  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ev  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    epc = '{32'h3020, 32'h3020, 32'h3020, 32'h3020, 32'h3024, 32'h3024, 32'h3028, 32'h302C};
    een = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ead = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h3028, 32'h302C, 32'h3030, 32'h3034};
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, st[i], 1'b0, 32'h0);
      checks++; if (id_valid !== ev[i]) begin errors++; $display("FAIL stall_valid[%0d]: got %b want %b", i, id_valid, ev[i]); end
      checks++; if (id_pc !== epc[i]) begin errors++; $display("FAIL stall_pc[%0d]: got %h want %h", i, id_pc, epc[i]); end
      if (ev[i]) begin
        checks++; if (id_instr !== (epc[i] ^ 32'hA5A5_0000)) begin errors++; $display("FAIL stall_instr[%0d]: got %h want %h", i, id_instr, epc[i] ^ 32'hA5A5_0000); end
      end
      checks++; if (imem_en !== een[i]) begin errors++; $display("FAIL stall_en[%0d]: got %b want %b", i, imem_en, een[i]); end
      if (een[i]) begin
        checks++; if (imem_addr !== ead[i]) begin errors++; $display("FAIL stall_addr[%0d]: got %h want %h", i, imem_addr, ead[i]); end
      end
    end
  endtask

  task automatic test_redirect;
    // cycle N: redirect to an unaligned target
    cyc(1'b0, 1'b0, 1'b1, 32'h3103);
    checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL redir_en_n: got %b want 0", imem_en); end
    checks++; if (id_pc !== 32'h3030) begin errors++; $display("FAIL redir_pc_n: got %h want 3030", id_pc); end
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_n1: got %b want 0", id_valid); end
    checks++; if (imem_en !== 1'b1) begin errors++; $display("FAIL redir_en_n1: got %b want 1", imem_en); end
    checks++; if (imem_addr !== 32'h3100) begin errors++; $display("FAIL redir_addr_n1: got %h want 3100", imem_addr); end
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_n2: got %b want 0", id_valid); end
    checks++; if (imem_addr !== 32'h3104) begin errors++; $display("FAIL redir_addr_n2: got %h want 3104", imem_addr); end
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL redir_valid_n3: got %b want 1", id_valid); end
    checks++; if (id_pc !== 32'h3100) begin errors++; $display("FAIL redir_pc_n3: got %h want 3100", id_pc); end
    checks++; if (id_instr !== 32'hA5A5_3100) begin errors++; $display("FAIL redir_instr_n3: got %h want a5a53100", id_instr); end
    checks++; if (id_pc4 !== 32'h3104) begin errors++; $display("FAIL redir_pc4_n3: got %h want 3104", id_pc4); end
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (id_pc !== 32'h3104 || id_valid !== 1'b1) begin errors++; $display("FAIL redir_pc_n4: got %h/%b want 3104/1", id_pc, id_valid); end
  endtask

  task automatic test_redirect_stall;
    logic        st  [8];
    logic        rd  [8];
    logic        ev  [8];
    logic [31:0] epc [8];
    logic        een [8];
    logic [31:0] ead [8];
    st  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rd  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ev  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    epc = '{32'h3108, 32'h3108, 32'h3108, 32'h3108, 32'h3108, 32'h3200, 32'h3200, 32'h3204};
    een = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    ead = '{32'h0, 32'h0, 32'h3200, 32'h0, 32'h0, 32'h3204, 32'h3208, 32'h320C};
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, st[i], rd[i], 32'h3200);
      checks++; if (id_valid !== ev[i]) begin errors++; $display("FAIL rs_valid[%0d]: got %b want %b", i, id_valid, ev[i]); end
      checks++; if (id_pc !== epc[i]) begin errors++; $display("FAIL rs_pc[%0d]: got %h want %h", i, id_pc, epc[i]); end
      checks++; if (imem_en !== een[i]) begin errors++; $display("FAIL rs_en[%0d]: got %b want %b", i, imem_en, een[i]); end
      if (een[i]) begin
        checks++; if (imem_addr !== ead[i]) begin errors++; $display("FAIL rs_addr[%0d]: got %h want %h", i, imem_addr, ead[i]); end
      end
    end
  endtask

  task automatic test_wrap;
    cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr1: got %h want fffffffc", imem_addr); end
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr2: got %h want 0", imem_addr); end
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (id_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc3: got %h want fffffffc", id_pc); end
    checks++; if (id_instr !== 32'h5A5A_FFFC) begin errors++; $display("FAIL wrap_instr3: got %h want 5a5afffc", id_instr); end
    checks++; if (id_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4_3: got %h want 0", id_pc4); end
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (id_pc !== 32'h0 || id_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc4: got %h/%b want 0/1", id_pc, id_valid); end
    checks++; if (id_instr !== 32'hA5A5_0000) begin errors++; $display("FAIL wrap_instr4: got %h want a5a50000", id_instr); end
    checks++; if (id_pc4 !== 32'h4) begin errors++; $display("FAIL wrap_pc4_4: got %h want 4", id_pc4); end
  endtask

  task automatic test_midreset;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL mrst_en: got %b want 0", imem_en); end
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b want 0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL mrst_instr: got %h want 0", id_instr); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL mrst_pc: got %h want 0", id_pc); end
    checks++; if (id_pc4 !== 32'h0) begin errors++; $display("FAIL mrst_pc4: got %h want 0", id_pc4); end
    checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h3000) begin errors++; $display("FAIL mrst_restart: got %b/%h want 1/3000", imem_en, imem_addr); end
`ifdef IFU_PERF_CNT_EN
    checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL mrst_fetch_cnt: got %0d want 0", fetch_cnt); end
    checks++; if (bubble_cnt !== 32'd0) begin errors++; $display("FAIL mrst_bubble_cnt: got %0d want 0", bubble_cnt); end
`endif
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid2: got %b want 0", id_valid); end
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h3000) begin errors++; $display("FAIL mrst_first: got %b/%h want 1/3000", id_valid, id_pc); end
    checks++; if (id_instr !== 32'hA5A5_3000) begin errors++; $display("FAIL mrst_instr3: got %h want a5a53000", id_instr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_wrap();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
